// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared RISC-V definitions for the load/store path: funct3 access codes,
// byte-enable width, the LSU state enum and a funct3 legality helper.
// Configuration macro used by the LSU: LSU_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

  localparam int BE_W = 4;

  // Load funct3 codes
  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;
  // Store funct3 codes
  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // True when funct3 names a real access for the given direction.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      ok = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
    end else begin
      ok = (funct3 == FUNCT3_B)  || (funct3 == FUNCT3_H)  || (funct3 == FUNCT3_W) ||
           (funct3 == FUNCT3_BU) || (funct3 == FUNCT3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational load formatter: picks the byte/halfword lane addressed by
// addr_lo out of the 32-bit memory word, then sign- or zero-extends it.
// Ports:
//   funct3   in  [2:0]  load size/sign code
//   addr_lo  in  [1:0]  low byte-address bits of the access
//   word     in  [31:0] raw memory read data
//   data     out [31:0] extended load result
// ---------------------------------------------------------------------------
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfword lane follows addr[1] only, matching the halfword byte enables.
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (funct3)
      FUNCT3_B:  data = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_H:  data = {{16{half_sel[15]}}, half_sel};
      FUNCT3_BU: data = {24'd0, byte_sel};
      FUNCT3_HU: data = {16'd0, half_sel};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store unit. Accepts one request in IDLE, issues a
// single memory access in BUSY, and pulses rsp_valid for one cycle in RESP.
// Illegal funct3 (and, with LSU_MISALIGN_TRAP_EN defined, misaligned
// halfword/word accesses) skip memory and respond with rsp_err=1.
// Without LSU_MISALIGN_TRAP_EN, misaligned accesses are forced to the
// naturally aligned lane and complete normally.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_store, req_funct3           operation and access size/sign
//   req_addr, req_wdata             byte address, right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err   completion pulse, load data, fault flag
//   mem_req/we/be/addr/wdata        memory request (held while BUSY)
//   mem_ack, mem_rdata              memory completion and read data
// ---------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       load_data;
  logic              misalign;
  logic              fault;
  logic [BE_W-1:0]   req_be;
  logic [31:0]       req_wdata_fmt;

  lsu_load_align u_load_align (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .word    (mem_rdata),
    .data    (load_data)
  );

  // Request-side decode: byte enables, store lane replication, fault check.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_be = 4'b0001 << req_addr[1:0];
      2'b01:   req_be = 4'b0011 << {req_addr[1], 1'b0};
      default: req_be = 4'b1111;
    endcase

    case (req_funct3[1:0])
      2'b00:   req_wdata_fmt = {4{req_wdata[7:0]}};
      2'b01:   req_wdata_fmt = {2{req_wdata[15:0]}};
      default: req_wdata_fmt = req_wdata;
    endcase

`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif

    fault = !funct3_legal(req_store, req_funct3) || misalign;
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata_fmt;
          be_d     = req_be;
          err_d    = fault;
          if (fault) begin
            rdata_d = 32'd0;
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          rdata_d = store_q ? 32'd0 : load_data;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      be_q     <= '0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory-side outputs are driven only while the access is outstanding,
  // so they read as zero in IDLE/RESP and after reset.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_err   = (state_q == RESP) && err_q;
    rsp_rdata = rdata_q;
    mem_req   = (state_q == BUSY);
    mem_we    = mem_req && store_q;
    mem_be    = mem_req ? be_q : '0;
    mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata = (mem_req && store_q) ? wdata_q : 32'd0;
  end

endmodule
